output_writeback_buffer: RTL and testbench

- Sits directly downstream of the convolution controller FSM and its output data shifter (ODS).
- Captures every output_valid pulse as one result entry {data, x, y, ch} into an elastic FIFO, then streams the entries to the host over a valid/ready handshake.
- The controller cannot stall mid-computation, so the block drives an almost-full backpressure flag the controller samples before starting a new output row.
- Tracks overflow and a completion count, and signals done when the whole output tensor has been delivered.

---
 rtl/output_writeback_buffer_pkg.sv | 26 ++
 rtl/output_writeback_buffer_if.sv | 26 ++
 rtl/output_writeback_buffer_sync_fifo.sv | 71 +++++++
 rtl/output_writeback_buffer.sv | 102 ++++++++++
 tb/tb_output_writeback_buffer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/output_writeback_buffer_pkg.sv
// Shared types and constants for the convolution output writeback path.
package conv_pkg;

  localparam int COORD_WIDTH        = 32;
  localparam int ACC_WIDTH_DEFAULT  = 32;

  typedef struct packed {
    logic [ACC_WIDTH_DEFAULT-1:0] data;
    logic [COORD_WIDTH-1:0]       x;
    logic [COORD_WIDTH-1:0]       y;
    logic [COORD_WIDTH-1:0]       ch;
  } result_entry_t;

  typedef enum logic {
    HOST_EMPTY    = 1'b0,
    HOST_HAS_DATA = 1'b1
  } host_state_e;

  function automatic logic [31:0] total_outputs(input int w, input int h, input int c);
    return 32'(w * h * c);
  endfunction

  localparam int          ENTRY_WIDTH   = $bits(result_entry_t);
  localparam logic [31:0] TOTAL_OUTPUTS = total_outputs(1024, 1024, 64);

endpackage

// File: rtl/output_writeback_buffer_if.sv
// Result stream in from the controller/ODS and out to the host.
interface output_writeback_buffer_if #(
  parameter int ACCUMULATION_WIDTH = 32
);
  logic                          in_valid;
  logic [ACCUMULATION_WIDTH-1:0] in_data;
  logic [31:0]                   in_x;
  logic [31:0]                   in_y;
  logic [31:0]                   in_ch;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACCUMULATION_WIDTH-1:0] out_data;
  logic [31:0]                   out_x;
  logic [31:0]                   out_y;
  logic [31:0]                   out_ch;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  out_valid, out_data, out_x, out_y, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output out_valid, out_data, out_x, out_y, out_ch
  );
endinterface

// File: rtl/output_writeback_buffer_sync_fifo.sv
// Registered (no fall-through) synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; the head is only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
endmodule

// File: rtl/output_writeback_buffer.sv
// Elastic buffer between the convolution controller and the host: captures
// results, applies almost-full backpressure, tracks overflow and completion.
module output_writeback_buffer
  import conv_pkg::*;
#(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  output_writeback_buffer_if.slave      bus,
  output logic                          stall_req,
  output logic                          overflow,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int          LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int          EW    = ACCUMULATION_WIDTH + 3 * COORD_WIDTH;
  localparam logic [31:0] TOTAL = total_outputs(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                                OUTPUT_NB_CHANNELS);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(ALMOST_FULL_MARGIN);

  host_state_e   state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [31:0]   delivered_q, delivered_d;
  logic          push, pop, fifo_full;
  logic [EW-1:0] wdata, rdata;
  logic [LW-1:0] level_w;

  // start takes priority: the coincident entry is dropped, not counted as overflow.
  assign push  = bus.in_valid & ~start;
  assign pop   = bus.out_valid & bus.out_ready & ~start;
  assign wdata = {bus.in_data, bus.in_x, bus.in_y, bus.in_ch};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clr_i     (start),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .level_o   (level_w),
    .full_o    (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    delivered_d = delivered_q;
    if (start) begin
      state_d     = HOST_EMPTY;
      overflow_d  = 1'b0;
      done_d      = 1'b0;
      delivered_d = '0;
    end else begin
      case (state_q)
        HOST_EMPTY:    if (push) state_d = HOST_HAS_DATA;
        HOST_HAS_DATA: if (pop && !push && level_w == LW'(1)) state_d = HOST_EMPTY;
        default:       state_d = HOST_EMPTY;
      endcase
      if (push && fifo_full && !pop) overflow_d = 1'b1;
      if (pop) begin
        delivered_d = delivered_q + 32'd1;
        if (delivered_d == TOTAL) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= HOST_EMPTY;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      delivered_q <= '0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      delivered_q <= delivered_d;
    end
  end

  assign bus.out_valid = (state_q == HOST_HAS_DATA);
  assign {bus.out_data, bus.out_x, bus.out_y, bus.out_ch} = bus.out_valid ? rdata : '0;

  assign stall_req = (DEPTH_L - level_w) <= MARGIN_L;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign level     = level_w;
endmodule

// File: tb/tb_output_writeback_buffer.sv
// Randomized and directed stimulus checked against a queue-based model.
module tb_output_writeback_buffer;
  import conv_pkg::*;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int TOTAL  = 2 * 2 * 2;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall_req, overflow, done;
  logic [4:0] level;

  output_writeback_buffer_if #(.ACCUMULATION_WIDTH(32)) bus ();

  output_writeback_buffer #(
    .ACCUMULATION_WIDTH (32),
    .FIFO_DEPTH         (DEPTH),
    .ALMOST_FULL_MARGIN (MARGIN),
    .FEATURE_MAP_WIDTH  (2),
    .FEATURE_MAP_HEIGHT (2),
    .OUTPUT_NB_CHANNELS (2)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n),
    .start     (start),
    .bus       (bus.slave),
    .stall_req (stall_req),
    .overflow  (overflow),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  result_entry_t m_q[$];
  bit            m_ovf, m_done;
  int unsigned   m_cnt;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 128'(bus.out_valid), 128'(m_q.size() != 0));
    chk("level", 128'(level), 128'(m_q.size()));
    chk("stall_req", 128'(stall_req), 128'((DEPTH - m_q.size()) <= MARGIN));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("done", 128'(done), 128'(m_done));
    if (m_q.size() != 0)
      chk("head", {bus.out_data, bus.out_x, bus.out_y, bus.out_ch}, m_q[0]);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf  = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: check state at negedge, drive inputs, advance model at posedge.
  task automatic step(input bit st, input bit iv, input logic [31:0] d, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] c, input bit rdy);
    int            sz;
    bit            popped;
    result_entry_t e;
    check_outputs();
    start         = st;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_ch     = c;
    bus.out_ready = rdy;
    @(posedge clk);
    if (st) begin
      model_clear();
    end else begin
      sz     = m_q.size();
      popped = (sz != 0) && rdy;
      if (popped) begin
        void'(m_q.pop_front());
        m_cnt++;
        if (m_cnt == TOTAL) m_done = 1'b1;
      end
      if (iv) begin
        if (sz == DEPTH && !popped) m_ovf = 1'b1;
        else begin
          e.data = d; e.x = x; e.y = y; e.ch = c;
          m_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, '0, '0, '0, '0, rdy);
  endtask

  task automatic push(input logic [31:0] d, input bit rdy);
    step(1'b0, 1'b1, d, d ^ 32'h11, d + 32'd7, d >> 1, rdy);
  endtask

  task automatic do_reset();
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    arst_n        = 1'b0;
    #1;
    model_clear();
    check_outputs();
    chk("rst_fields", {bus.out_data, bus.out_x, bus.out_y, bus.out_ch}, '0);
    @(negedge clk);
    check_outputs();
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int pct[6] = '{10, 50, 90, 30, 95, 60};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    // single push, pop on the following edge
    step(1'b0, 1'b1, 32'h0000_00AA, 32'd1, 32'd2, 32'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // fill through almost-full to full, then one overflowing push
    for (int i = 0; i < 17; i++) push(32'h100 + 32'(i), 1'b0);
    idle(1'b0);

    // push and pop on a full FIFO, then drain to see the new entry last
    push(32'hBEEF, 1'b1);
    for (int i = 0; i < 17; i++) idle(1'b1);

    // ready toggling while back-to-back pushes arrive
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i), (i % 2) == 0);
    for (int i = 0; i < 10; i++) idle((i % 2) == 0);

    // completion count reaches TOTAL, start clears everything
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    push(32'h3FF, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 32'h400, '0, '0, '0, 1'b1);
    idle(1'b0);

    // asynchronous reset with entries held
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 1'b0);
    do_reset();
    idle(1'b0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 99) < 60, $urandom, $urandom,
           $urandom, $urandom, $urandom_range(0, 99) < pct[i / 100]);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
